// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared types for the instruction fetch stage: bus request/response
//   structs, the fetch->decode payload, the fetch FSM state encoding and the
//   reset PC. Also small PC helpers used by fetch_unit.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  typedef logic [63:0] addr_t;

  // Boot address; feeds the PC_RESET parameter of fetch_unit.
  localparam addr_t PCINIT = 64'h8000_0000;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic [31:0] raw_instr;
    addr_t       pc;
    logic        valid;
  } fetch_data_t;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  // Sequential PC; plain 64-bit wrap-around.
  function automatic addr_t pc_next(input addr_t pc);
    return pc + addr_t'(INSTR_BYTES);
  endfunction

  // Instructions are word aligned: the low two bits are always dropped.
  function automatic addr_t align_word(input addr_t a);
    return {a[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_hold_buf.sv
// -----------------------------------------------------------------------------
// fetch_hold_buf
//   One-entry {instr, pc} buffer. Catches a fetched word that arrives while
//   decode is stalled so the bus request can retire.
// Ports
//   clk      in   core clock
//   reset    in   synchronous, active-high; empties the buffer
//   load_i   in   capture instr_i/pc_i and mark valid
//   clear_i  in   empty the buffer (wins over load_i)
//   instr_i  in   32-bit instruction word
//   pc_i     in   address of instr_i
//   valid_o  out  buffer holds an instruction
//   instr_o  out  buffered instruction
//   pc_o     out  buffered pc
// -----------------------------------------------------------------------------
module fetch_hold_buf
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  addr_t       pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output addr_t       pc_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  addr_t       pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Owns the PC, issues one word fetch at a time on
//   the instruction bus and presents a registered {raw_instr, pc, valid} to
//   decode. Honours the decode stall and the execute redirect.
// Parameters
//   PC_RESET        PC loaded on reset (default PCINIT)
// Ports
//   clk             in   core clock
//   reset           in   synchronous, active-high
//   ireq            out  {valid, addr} fetch request
//   iresp           in   {addr_ok, data_ok, data} fetch response (addr_ok unused)
//   stall           in   decode cannot accept; dataF holds
//   redirect_valid  in   flush and restart at redirect_pc
//   redirect_pc     in   new PC, low two bits ignored
//   dataF           out  registered fetch payload to decode
//   fetch_cnt       out  instructions accepted by decode   (FETCH_PERF_CNT_EN)
//   wait_cnt        out  cycles spent waiting for data_ok  (FETCH_PERF_CNT_EN)
// Build option
//   FETCH_PERF_CNT_EN  adds the two 64-bit performance counters.
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter addr_t PC_RESET = PCINIT
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        stall,
  input  logic        redirect_valid,
  input  addr_t       redirect_pc,
  output fetch_data_t dataF
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [63:0] fetch_cnt,
  output logic [63:0] wait_cnt
`endif
);

  fetch_state_t state_q;
  addr_t        pc_q;
  addr_t        req_addr_q;  // address still on the bus while discarding
  fetch_data_t  dataF_q;

  logic         hold_load;
  logic         hold_clear;
  logic         hold_valid;
  logic [31:0]  hold_instr;
  addr_t        hold_pc;
  addr_t        redirect_target;

  logic         unused_addr_ok;
  assign unused_addr_ok = iresp.addr_ok;

  assign redirect_target = align_word(redirect_pc);

  // Request is a pure function of state so valid/addr cannot change until
  // data_ok retires it; reset gates valid off in the same cycle.
  assign ireq.valid = !reset && (state_q != HOLD);
  assign ireq.addr  = (state_q == DISCARD) ? req_addr_q : pc_q;

  always_comb begin
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    if (!reset) begin
      hold_load  = !redirect_valid && (state_q == REQ) && iresp.data_ok && stall;
      hold_clear = redirect_valid || ((state_q == HOLD) && !stall);
    end
  end

  fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .reset   (reset),
    .load_i  (hold_load),
    .clear_i (hold_clear),
    .instr_i (iresp.data),
    .pc_i    (pc_q),
    .valid_o (hold_valid),
    .instr_o (hold_instr),
    .pc_o    (hold_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= REQ;
      pc_q       <= PC_RESET;
      req_addr_q <= PC_RESET;
      dataF_q    <= '0;
    end else if (redirect_valid) begin
      // Flush wins over stall: decode gets a bubble regardless.
      dataF_q <= '0;
      pc_q    <= redirect_target;
      case (state_q)
        REQ: begin
          if (!iresp.data_ok) begin
            // Outstanding request must still complete; remember its address.
            state_q    <= DISCARD;
            req_addr_q <= pc_q;
          end
        end
        HOLD:    state_q <= REQ;
        // A response landing together with the redirect still retires the
        // stale request, otherwise DISCARD would wait forever.
        DISCARD: if (iresp.data_ok) state_q <= REQ;
        default: state_q <= REQ;
      endcase
    end else begin
      case (state_q)
        REQ: begin
          if (iresp.data_ok) begin
            pc_q <= pc_next(pc_q);
            if (stall) begin
              state_q <= HOLD;
            end else begin
              dataF_q <= '{raw_instr: iresp.data, pc: pc_q, valid: 1'b1};
            end
          end else if (!stall) begin
            dataF_q.valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            dataF_q <= '{raw_instr: hold_instr, pc: hold_pc, valid: hold_valid};
            state_q <= REQ;
          end
        end
        DISCARD: begin
          if (!stall) dataF_q.valid <= 1'b0;
          if (iresp.data_ok) state_q <= REQ;
        end
        default: state_q <= REQ;
      endcase
    end
  end

  assign dataF = dataF_q;

`ifdef FETCH_PERF_CNT_EN
  logic [63:0] fetch_cnt_q;
  logic [63:0] wait_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if (dataF_q.valid && !stall) fetch_cnt_q <= fetch_cnt_q + 64'd1;
      if (ireq.valid && !iresp.data_ok) wait_cnt_q <= wait_cnt_q + 64'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign wait_cnt  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. Stimulus pushes the instructions decode is
//   expected to accept into a queue; a monitor pops one entry each cycle
//   dataF.valid is high with no stall and compares pc and raw_instr.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  ibus_req_t   ireq;
  ibus_resp_t  iresp = '0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  addr_t       redirect_pc = '0;
  fetch_data_t dataF;
`ifdef FETCH_PERF_CNT_EN
  logic [63:0] fetch_cnt;
  logic [63:0] wait_cnt;
`endif

  fetch_unit #(.PC_RESET(64'h8000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq           (ireq),
    .iresp          (iresp),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dataF          (dataF)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .wait_cnt       (wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    addr_t       pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Memory contents seen by the fetch unit: a fixed pattern of the address.
  function automatic logic [31:0] mem_word(input addr_t a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: inputs change just after posedge, then wait to negedge.
  task automatic drive(input logic rst, input logic ok, input logic st,
                       input logic rv, input addr_t rpc);
    @(posedge clk);
    #1;
    reset          = rst;
    iresp.addr_ok  = ok;
    iresp.data_ok  = ok;
    iresp.data     = ok ? mem_word(ireq.addr) : 32'h0;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
  endtask

  task automatic push_cur();
    exp_t e;
    e.instr = mem_word(ireq.addr);
    e.pc    = ireq.addr;
    exp_q.push_back(e);
  endtask

  task automatic chk_req(input string name, input addr_t addr);
    chk({name, "_valid"}, 64'(ireq.valid), 64'd1);
    chk({name, "_addr"}, ireq.addr, addr);
  endtask

  initial begin
    fork
      // Monitor / scoreboard
      begin
        forever begin
          @(negedge clk);
          if (reset) begin
            chk("rst_ireq_valid", 64'(ireq.valid), 64'd0);
          end else if (dataF.valid && !stall) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL sb_unexpected: got pc %h, expected no instruction", dataF.pc);
            end else begin
              exp_t e;
              e = exp_q.pop_front();
              $display("deliver pc=%h instr=%h", dataF.pc, dataF.raw_instr);
              chk("sb_pc", dataF.pc, e.pc);
              chk("sb_instr", 64'(dataF.raw_instr), 64'(e.instr));
            end
          end
        end
      end
      // Stimulus
      begin
        repeat (3) drive(1, 0, 0, 0, '0);

        // 1: back-to-back data_ok
        drive(0, 1, 0, 0, '0);
        chk_req("t1_req0", 64'h8000_0000);
        chk("t1_dataF_after_reset", 64'(dataF.valid), 64'd0);
        push_cur();
        drive(0, 1, 0, 0, '0); chk_req("t1_req1", 64'h8000_0004); push_cur();
        drive(0, 1, 0, 0, '0); chk_req("t1_req2", 64'h8000_0008); push_cur();

        // 2: slow response, address stable
        for (int i = 0; i < 3; i++) begin
          drive(0, 0, 0, 0, '0);
          chk_req("t2_wait", 64'h8000_000C);
          if (i > 0) chk("t2_wait_bubble", 64'(dataF.valid), 64'd0);
        end
        drive(0, 1, 0, 0, '0);
        chk_req("t2_dataok", 64'h8000_000C);
        chk("t2_dataok_bubble", 64'(dataF.valid), 64'd0);
        push_cur();

        // 3: stall on data_ok at 8000_0010
        drive(0, 1, 1, 0, '0); chk_req("t3_req", 64'h8000_0010); push_cur();
        drive(0, 0, 1, 0, '0);
        chk("t3_hold_noreq", 64'(ireq.valid), 64'd0);
        chk("t3_held_valid", 64'(dataF.valid), 64'd1);
        chk("t3_held_pc", dataF.pc, 64'h8000_000C);
        drive(0, 0, 0, 0, '0);
        chk("t3_release_noreq", 64'(ireq.valid), 64'd0);
        drive(0, 1, 0, 0, '0); chk_req("t3_resume", 64'h8000_0014); push_cur();

        // 4: redirect while waiting
        drive(0, 0, 0, 0, '0); chk_req("t4_wait", 64'h8000_0018);
        drive(0, 0, 0, 1, 64'h8000_1003);
        drive(0, 0, 0, 0, '0);
        chk_req("t4_discard", 64'h8000_0018);
        chk("t4_bubble", 64'(dataF.valid), 64'd0);
        drive(0, 1, 0, 0, '0); chk_req("t4_late", 64'h8000_0018);
        drive(0, 1, 0, 0, '0);
        chk_req("t4_newreq", 64'h8000_1000);
        chk("t4_dropped", 64'(dataF.valid), 64'd0);

        // 5: redirect + stall with a valid instr on dataF
        drive(0, 0, 1, 1, 64'h8000_2000);
        chk("t5_pre_valid", 64'(dataF.valid), 64'd1);
        chk("t5_pre_pc", dataF.pc, 64'h8000_1000);
        chk("t5_pre_instr", 64'(dataF.raw_instr), 64'(mem_word(64'h8000_1000)));
        drive(0, 0, 0, 0, '0);
        chk("t5_bubble", 64'(dataF.valid), 64'd0);
        chk_req("t5_discard", 64'h8000_1004);
        drive(0, 1, 0, 0, '0);
        drive(0, 1, 0, 0, '0); chk_req("t5_newreq", 64'h8000_2000); push_cur();

        // Redirect coinciding with data_ok: no discard phase
        drive(0, 1, 0, 1, 64'h8000_3000);
        drive(0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        chk_req("rd_dataok_req", 64'h8000_3000);
        chk("rd_dataok_bubble", 64'(dataF.valid), 64'd0);

        // PC wrap-around
        drive(0, 1, 0, 0, '0); chk_req("wrap_top", 64'hFFFF_FFFF_FFFF_FFFC); push_cur();
        drive(0, 1, 0, 0, '0); chk_req("wrap_zero", 64'h0); push_cur();

        // 6: reset while waiting
        drive(0, 0, 0, 0, '0); chk_req("t6_wait", 64'h4);
        drive(1, 0, 0, 0, '0);
        chk("t6_rst_ireq", 64'(ireq.valid), 64'd0);
        drive(0, 1, 0, 0, '0);
        chk_req("t6_after_rst", 64'h8000_0000);
        chk("t6_dataF", 64'(dataF.valid), 64'd0);
        push_cur();
        drive(0, 0, 0, 0, '0);
        drive(0, 0, 0, 0, '0);
      end
      // Watchdog
      begin
        #100000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "timeout");
      end
    join_any

    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
